imem_loader: RTL and testbench

//  Byte-stream program loader: the writer for the 8-bit-wide, byte-addressed memories.

---
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed stream (base address, length,
// payload, checksum) over valid/ready and writes each payload byte to memory.
module imem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        byte_count
);

  localparam int unsigned TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]         state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [7:0]         len, len_n;
  logic [7:0]         sum, sum_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [7:0]         cnt_n;
  logic               done_n, error_n, busy_n;
  logic               we_n;
  logic [ADDR_W-1:0]  waddr_n;
  logic [7:0]         wdata_n;
  logic               xfer;

  // busy is a decoded copy of the state register, so in_ready has no input path
  assign in_ready = busy;
  assign xfer     = busy && in_valid;

  // State register and all registered outputs; reset aborts any frame at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      len        <= '0;
      sum        <= '0;
      timer      <= '0;
      byte_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      len        <= len_n;
      sum        <= sum_n;
      timer      <= timer_n;
      byte_count <= cnt_n;
      done       <= done_n;
      error      <= error_n;
      busy       <= busy_n;
      mem_we     <= we_n;
      mem_waddr  <= waddr_n;
      mem_wdata  <= wdata_n;
    end
  end

  // Next-state, stall timer, checksum and memory write decode
  always_comb begin
    state_n = state;
    addr_n  = addr;
    len_n   = len;
    sum_n   = sum;
    timer_n = timer;
    cnt_n   = byte_count;
    done_n  = done;
    error_n = error;
    we_n    = 1'b0;
    waddr_n = mem_waddr;
    wdata_n = mem_wdata;

    // Stall watchdog: any accepted byte restarts it; TIMEOUT of zero disables it
    if (busy) begin
      if (in_valid) begin
        timer_n = '0;
      end else if ((TIMEOUT != 0) && ((32'(timer) + 32'd1) == TIMEOUT)) begin
        state_n = S_ERR;
        error_n = 1'b1;
      end else begin
        timer_n = timer + TIMER_W'(1);
      end
    end

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n = S_ADDR;
          done_n  = 1'b0;
          error_n = 1'b0;
          cnt_n   = '0;
          sum_n   = '0;
          timer_n = '0;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          addr_n  = ADDR_W'(in_data);
          sum_n   = in_data;
          state_n = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          len_n   = in_data;
          sum_n   = sum + in_data;
          state_n = (in_data != 8'd0) ? S_DATA : S_CSUM;
        end
      end
      S_DATA: begin
        if (xfer) begin
          we_n    = 1'b1;
          waddr_n = addr;
          wdata_n = in_data;
          addr_n  = addr + ADDR_W'(1);
          cnt_n   = byte_count + 8'd1;
          sum_n   = sum + in_data;
          if ((byte_count + 8'd1) == len) begin
            state_n = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (8'(sum + in_data) == 8'd0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_ERR;
            error_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_ADDR) || (state_n == S_LEN) ||
             (state_n == S_DATA) || (state_n == S_CSUM);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, bad checksum, address wrap,
// empty payload, stall timeout and mid-frame reset.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] byte_count;

  int vectors;
  int errors;

  imem_loader #(.ADDR_W(8), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Offer one byte for one cycle, then check the write port in the following cycle
  task automatic send(input string tag, input logic [7:0] b, input logic we,
                      input logic [7:0] a, input logic [7:0] d);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    chk({tag, "_we"}, 32'(mem_we), 32'(we));
    if (we) begin
      chk({tag, "_addr"}, 32'(mem_waddr), 32'(a));
      chk({tag, "_data"}, 32'(mem_wdata), 32'(d));
    end
  endtask

  task automatic status(input string tag, input logic d, input logic e, input logic [7:0] n);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_count"}, 32'(byte_count), 32'(n));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    status("rst", 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    tick();

    // Good frame: three consecutive writes at 10..12
    pulse_start();
    send("t1_base", 8'h10, 1'b0, 8'h00, 8'h00);
    send("t1_len",  8'h03, 1'b0, 8'h00, 8'h00);
    send("t1_p0",   8'hA1, 1'b1, 8'h10, 8'hA1);
    send("t1_p1",   8'hB2, 1'b1, 8'h11, 8'hB2);
    send("t1_p2",   8'hC3, 1'b1, 8'h12, 8'hC3);
    send("t1_cs",   8'hD7, 1'b0, 8'h00, 8'h00);
    status("t1", 1'b1, 1'b0, 8'd3);
    chk("t1_ready_after", 32'(in_ready), 32'd0);

    // Bad checksum: writes still land, error set
    pulse_start();
    chk("t2_done_cleared", 32'(done), 32'd0);
    send("t2_base", 8'h10, 1'b0, 8'h00, 8'h00);
    send("t2_len",  8'h03, 1'b0, 8'h00, 8'h00);
    send("t2_p0",   8'hA1, 1'b1, 8'h10, 8'hA1);
    send("t2_p1",   8'hB2, 1'b1, 8'h11, 8'hB2);
    send("t2_p2",   8'hC3, 1'b1, 8'h12, 8'hC3);
    send("t2_cs",   8'h00, 1'b0, 8'h00, 8'h00);
    status("t2", 1'b0, 1'b1, 8'd3);

    // Address wrap FE, FF, 00; a start pulse mid-frame must be ignored
    pulse_start();
    chk("t3_error_cleared", 32'(error), 32'd0);
    send("t3_base", 8'hFE, 1'b0, 8'h00, 8'h00);
    start = 1'b1;
    send("t3_len",  8'h03, 1'b0, 8'h00, 8'h00);
    start = 1'b0;
    send("t3_p0",   8'h11, 1'b1, 8'hFE, 8'h11);
    send("t3_p1",   8'h22, 1'b1, 8'hFF, 8'h22);
    send("t3_p2",   8'h33, 1'b1, 8'h00, 8'h33);
    send("t3_cs",   8'h99, 1'b0, 8'h00, 8'h00);
    status("t3", 1'b1, 1'b0, 8'd3);

    // Empty payload
    pulse_start();
    chk("t4_count_cleared", 32'(byte_count), 32'd0);
    send("t4_base", 8'h20, 1'b0, 8'h00, 8'h00);
    send("t4_len",  8'h00, 1'b0, 8'h00, 8'h00);
    send("t4_cs",   8'hE0, 1'b0, 8'h00, 8'h00);
    status("t4", 1'b1, 1'b0, 8'd0);

    // Stall timeout after 8 idle cycles inside a frame
    pulse_start();
    send("t5_base", 8'h10, 1'b0, 8'h00, 8'h00);
    send("t5_len",  8'h02, 1'b0, 8'h00, 8'h00);
    send("t5_p0",   8'h55, 1'b1, 8'h10, 8'h55);
    repeat (7) tick();
    chk("t5_error_at7", 32'(error), 32'd0);
    chk("t5_ready_at7", 32'(in_ready), 32'd1);
    tick();
    status("t5", 1'b0, 1'b1, 8'd1);
    chk("t5_ready_at8", 32'(in_ready), 32'd0);
    repeat (3) tick();
    chk("t5_ready_later", 32'(in_ready), 32'd0);
    chk("t5_we_later", 32'(mem_we), 32'd0);

    // Reset between 2nd and 3rd payload byte clears everything without an edge
    pulse_start();
    send("t6_base", 8'h10, 1'b0, 8'h00, 8'h00);
    send("t6_len",  8'h03, 1'b0, 8'h00, 8'h00);
    send("t6_p0",   8'hA1, 1'b1, 8'h10, 8'hA1);
    send("t6_p1",   8'hB2, 1'b1, 8'h11, 8'hB2);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", 32'(mem_we), 32'd0);
    chk("t6_rst_addr", 32'(mem_waddr), 32'd0);
    chk("t6_rst_data", 32'(mem_wdata), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    status("t6_rst", 1'b0, 1'b0, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_we", 32'(mem_we), 32'd0);
    pulse_start();
    send("t6_base2", 8'h10, 1'b0, 8'h00, 8'h00);
    send("t6_len2",  8'h03, 1'b0, 8'h00, 8'h00);
    send("t6_q0",    8'hA1, 1'b1, 8'h10, 8'hA1);
    send("t6_q1",    8'hB2, 1'b1, 8'h11, 8'hB2);
    send("t6_q2",    8'hC3, 1'b1, 8'h12, 8'hC3);
    send("t6_cs2",   8'hD7, 1'b0, 8'h00, 8'h00);
    status("t6", 1'b1, 1'b0, 8'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
